iir_decimator: RTL and testbench
================================

Name: iir_decimator

Overview:
- Stage directly downstream of filter_iir: consumes its filtered S(NB_SAMPLE,NBF_SAMPLE) stream (one sample per clock at 48 kS/s) and decimates it by 2^LOG2_DEC using accumulate-and-dump (boxcar average).
- Presents each averaged sample on a valid/ready output with a one-entry holding register and a sticky overflow flag for results lost to backpressure.
- Output format is the same as the input format, so later stages reuse the same fixed-point definitions.

Parameters:
- NB_SAMPLE, 9: total bits of input and output samples (signed).
- NBF_SAMPLE, 7: fractional bits. Carried through unchanged; no arithmetic use.
- LOG2_DEC, 3: log2 of the decimation factor DEC (default DEC = 8). Legal range 1..6.
- NB_ACC, NB_SAMPLE+LOG2_DEC: accumulator width, sized so the sum can never overflow.

Ports:
- clock, input, 1: system clock.
- i_reset, input, 1: reset, asynchronous assert, active-low.
- x_i, input, NB_SAMPLE: signed input sample from filter_iir.
- x_valid_i, input, 1: x_i is valid this cycle. Counted only when high.
- y_o, output, NB_SAMPLE: signed decimated sample.
- y_valid_o, output, 1: y_o holds an unconsumed result.
- y_ready_i, input, 1: the consumer accepts y_o when y_valid_o && y_ready_i.
- ovf_o, output, 1: sticky flag. Set when a completed result is dropped.

Behaviour:
- Reset: i_reset low asynchronously clears acc, cnt, y_o, y_valid_o and ovf_o to 0. Deassertion is synchronised to clock outside this block.
- Reset mid-frame discards the partial sum. The next frame needs a full DEC valid samples.
- Counter cnt (LOG2_DEC bits) increments only on x_valid_i and wraps from DEC-1 to 0. Cycles with x_valid_i low leave acc and cnt unchanged.
- Accumulation: on x_valid_i with cnt < DEC-1, acc <= acc + sign-extended x_i.
- Dump: on x_valid_i with cnt == DEC-1:
  - sum = acc + x_i.
  - res = sum >>> LOG2_DEC (arithmetic shift, floor).
  - acc <= 0.
- Result width: res always fits in NB_SAMPLE bits because the average of in-range values stays in range. No saturation logic is required.
- Latency: y_valid_o rises on the clock edge that samples the DEC-th valid input. y_o is visible in the following cycle.
- Output register:
  - Load res when the register is empty, or when it is being consumed this cycle (y_valid_o && y_ready_i). The simultaneous consume-and-load case keeps y_valid_o at 1 with no bubble and does not set overflow.
  - If the register is full and not consumed when res completes, discard res, keep the old y_o and set ovf_o = 1.
  - A handshake with no new result clears y_valid_o. y_o holds its last value.
- ovf_o is cleared only by reset.
- y_ready_i has no effect on accumulation. The input side never stalls, because filter_iir cannot be back-pressured.

Optional Feature:
- Macro: IIR_DECIMATOR_ROUND_EN.
- Defined: res = (sum + 2^(LOG2_DEC-1)) >>> LOG2_DEC, i.e. round half up.
  - Range check: max 8*255+4 -> 255; min -2048+4 -> -256. Still no overflow.
- Undefined: plain floor (truncation) as above. No adder is inferred.

Decomposition:
- Shared package fixed_pkg:
  - NB_SAMPLE and NBF_SAMPLE defaults.
  - Function acc_width(nb, log2dec).
  - typedef of the signed sample type.
  - These are also used by filter_iir.
- One sub-module, out_hold_reg: the valid/ready holding register that generates the overflow.
- The accumulator and counter stay in the top module.

Test Plan:
- Constant x_i=64 (0.5) with x_valid_i=1 and y_ready_i=1 for 16 cycles -> two results of y_o=64.
  - y_valid_o pulses one cycle each, 8 cycles apart; the first appears the cycle after the 8th sample.
- Pattern 1,-2 repeated (sum -4) -> y_o=-1 without the macro; y_o=0 with IIR_DECIMATOR_ROUND_EN.
- Extremes:
  - 8x255 -> y_o=255 (both builds).
  - 8x(-256) -> y_o=-256 (both builds).
- Backpressure: y_ready_i=0 for 16 valid samples of 10 then 20.
  - y_o stays 10, y_valid_o=1, ovf_o=1 after the 16th sample.
  - Then y_ready_i=1 -> one handshake and y_valid_o falls.
- Gapped input: x_valid_i toggling every other cycle with x_i=32 -> result 32 after 8 valid samples (16 clocks). Invalid-cycle x_i=255 is ignored.
- Reset mid-frame: 5 samples of 100, assert i_reset, then 8 samples of 40 -> y_o=40 with ovf_o=0.

Source files
------------

// File: rtl/fixed_pkg.sv
// Shared fixed-point definitions for the filter_iir / iir_decimator audio chain.
// Holds the default sample format S(9,7), the signed sample type and the
// accumulator-width helper that sizes a sum of 2^log2dec samples so it cannot overflow.
package fixed_pkg;

  localparam int NB_SAMPLE_DFLT  = 9;
  localparam int NBF_SAMPLE_DFLT = 7;

  typedef logic signed [NB_SAMPLE_DFLT-1:0] sample_t;

  // A sum of 2^log2dec values of nb signed bits needs log2dec extra bits.
  function automatic int acc_width(input int nb, input int log2dec);
    return nb + log2dec;
  endfunction

endpackage

// File: rtl/out_hold_reg.sv
// Purpose: one-entry valid/ready holding register for decimated results, with sticky overflow.
// Latency: a result presented on res_vld is visible on y_dat/y_vld after one clock edge.
// Backpressure: a result arriving while full and not consumed is dropped and sets ovf.
// Ports: clock, i_reset (async active-low); res_dat/res_vld in; y_dat/y_vld/y_rdy out
//        handshake; ovf sticky drop flag, cleared only by reset.
module out_hold_reg
  import fixed_pkg::*;
#(
  parameter int W = NB_SAMPLE_DFLT
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic signed [W-1:0] res_dat,
  input  logic                res_vld,
  output logic signed [W-1:0] y_dat,
  output logic                y_vld,
  input  logic                y_rdy,
  output logic                ovf
);

  // Space is available when empty or when the current entry leaves this cycle,
  // which lets a back-to-back load happen with no bubble.
  logic take;
  assign take = !y_vld || y_rdy;

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      y_dat <= '0;
      y_vld <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (res_vld) begin
        if (take) begin
          y_dat <= res_dat;
          y_vld <= 1'b1;
        end else begin
          ovf <= 1'b1;
        end
      end else if (y_rdy) begin
        // Handshake with nothing new behind it: y_dat keeps its last value.
        y_vld <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/iir_decimator.sv
// Purpose: decimate the filter_iir stream by 2^LOG2_DEC with accumulate-and-dump averaging.
// Latency: y_valid_o rises on the edge that samples the DEC-th valid input.
// Backpressure: input never stalls; a result finding the output full is dropped, ovf_o set.
// Ports: clock, i_reset (async active-low); x_i/x_valid_i input samples;
//        y_o/y_valid_o/y_ready_i averaged output handshake; ovf_o sticky drop flag.
// Build option: define IIR_DECIMATOR_ROUND_EN for round-half-up averaging
//               (default is floor, with no extra adder).
module iir_decimator
  import fixed_pkg::*;
#(
  parameter int NB_SAMPLE  = NB_SAMPLE_DFLT,
  parameter int NBF_SAMPLE = NBF_SAMPLE_DFLT,
  parameter int LOG2_DEC   = 3,
  parameter int NB_ACC     = acc_width(NB_SAMPLE, LOG2_DEC)
) (
  input  logic                        clock,
  input  logic                        i_reset,
  input  logic signed [NB_SAMPLE-1:0] x_i,
  input  logic                        x_valid_i,
  output logic signed [NB_SAMPLE-1:0] y_o,
  output logic                        y_valid_o,
  input  logic                        y_ready_i,
  output logic                        ovf_o
);

  // The fractional point only travels with the data; it must lie inside the word.
  if (LOG2_DEC < 1 || LOG2_DEC > 6 || NBF_SAMPLE >= NB_SAMPLE ||
      NB_ACC != NB_SAMPLE + LOG2_DEC) begin : g_param_check
    $error("iir_decimator: illegal parameter combination");
  end

  // DEC-1 is all ones, so the counter wraps to 0 by plain increment.
  localparam logic [LOG2_DEC-1:0] CNT_LAST = '1;

  logic [LOG2_DEC-1:0]        cnt;
  logic signed [NB_ACC-1:0]   acc;
  logic signed [NB_ACC-1:0]   x_ext;
  logic signed [NB_ACC-1:0]   sum;
  logic signed [NB_SAMPLE-1:0] res;
  logic                       dump;

  assign x_ext = NB_ACC'(x_i);
  assign sum   = acc + x_ext;
  assign dump  = x_valid_i && (cnt == CNT_LAST);

`ifdef IIR_DECIMATOR_ROUND_EN
  // Adding half an output LSB before the floor shift rounds half up; the
  // accumulator headroom still covers the extra term at both extremes.
  localparam logic signed [NB_ACC-1:0] HALF_LSB = NB_ACC'(2 ** (LOG2_DEC - 1));
  assign res = NB_SAMPLE'((sum + HALF_LSB) >>> LOG2_DEC);
`else
  // Arithmetic shift of the full sum = floor of the average; always in range.
  assign res = NB_SAMPLE'(sum >>> LOG2_DEC);
`endif

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      acc <= '0;
      cnt <= '0;
    end else if (x_valid_i) begin
      cnt <= cnt + 1'b1;
      acc <= dump ? '0 : sum;
    end
  end

  out_hold_reg #(
    .W(NB_SAMPLE)
  ) u_out_hold_reg (
    .clock   (clock),
    .i_reset (i_reset),
    .res_dat (res),
    .res_vld (dump),
    .y_dat   (y_o),
    .y_vld   (y_valid_o),
    .y_rdy   (y_ready_i),
    .ovf     (ovf_o)
  );

endmodule

// File: tb/tb_iir_decimator.sv
// Self-checking bench for iir_decimator: directed cases plus random traffic,
// compared against a frame-level averaging model through a result scoreboard.
module tb_iir_decimator;
  import fixed_pkg::*;

  localparam int DEC = 8;
`ifdef IIR_DECIMATOR_ROUND_EN
  localparam int PAT_EXP = 0;
`else
  localparam int PAT_EXP = -1;
`endif

  logic    clock = 1'b0;
  logic    i_reset;
  sample_t x_i;
  logic    x_valid_i;
  sample_t y_o;
  logic    y_valid_o;
  logic    y_ready_i;
  logic    ovf_o;

  always #5 clock = ~clock;

  iir_decimator dut (
    .clock     (clock),
    .i_reset   (i_reset),
    .x_i       (x_i),
    .x_valid_i (x_valid_i),
    .y_o       (y_o),
    .y_valid_o (y_valid_o),
    .y_ready_i (y_ready_i),
    .ovf_o     (ovf_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: samples of the current frame, results expected to
  // be handed over (in order), and what the output side should look like.
  int sbq[$];
  int frame[$];
  bit m_occ;
  bit m_ovf;
  int m_hold;

  function automatic int avg_of(input int s_in);
    int s;
    int q;
    s = s_in;
`ifdef IIR_DECIMATOR_ROUND_EN
    s = s + DEC / 2;
`endif
    q = s / DEC;
    if ((s % DEC) != 0 && s < 0) q = q - 1;
    return q;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every handshake must deliver the oldest outstanding expected result.
  always @(negedge clock) begin
    if (i_reset && y_valid_o && y_ready_i) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL handshake: got %0d expected no result (t=%0t)", int'(y_o), $time);
      end else begin
        int exp;
        exp = sbq.pop_front();
        if (int'(y_o) !== exp) begin
          errors++;
          $display("FAIL handshake: got %0d expected %0d (t=%0t)", int'(y_o), exp, $time);
        end
      end
    end
  end

  // One clock of stimulus; called just after a rising edge.
  task automatic step(input int x, input bit vld, input bit rdy);
    bit consumed;
    bit got;
    int s;
    int r;
    chk("y_valid", int'(y_valid_o), int'(m_occ));
    chk("ovf", int'(ovf_o), int'(m_ovf));
    chk("y_hold", int'(y_o), m_hold);
    x_i       = sample_t'(x);
    x_valid_i = vld;
    y_ready_i = rdy;
    consumed = m_occ && rdy;
    got = 1'b0;
    r = 0;
    if (vld) begin
      frame.push_back(x);
      if (frame.size() == DEC) begin
        s = 0;
        foreach (frame[i]) s += frame[i];
        r = avg_of(s);
        frame.delete();
        got = 1'b1;
      end
    end
    if (got) begin
      if (!m_occ || consumed) begin
        sbq.push_back(r);
        m_occ  = 1'b1;
        m_hold = r;
      end else begin
        m_ovf = 1'b1;
      end
    end else if (consumed) begin
      m_occ = 1'b0;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    i_reset   = 1'b0;
    x_valid_i = 1'b0;
    #1;
    chk("rst_y", int'(y_o), 0);
    chk("rst_valid", int'(y_valid_o), 0);
    chk("rst_ovf", int'(ovf_o), 0);
    sbq.delete();
    frame.delete();
    m_occ  = 1'b0;
    m_ovf  = 1'b0;
    m_hold = 0;
    @(posedge clock);
    #1;
    i_reset = 1'b1;
  endtask

  initial begin
    i_reset   = 1'b0;
    x_i       = '0;
    x_valid_i = 1'b0;
    y_ready_i = 1'b0;
    #12;
    do_reset();

    // Constant 0.5: two results of 64, eight cycles apart.
    repeat (16) step(64, 1'b1, 1'b1);
    chk("const_y", int'(y_o), 64);
    chk("const_valid", int'(y_valid_o), 1);

    // 1,-2 pattern: sum -4, floor -> -1, rounded -> 0.
    repeat (4) begin
      step(1, 1'b1, 1'b1);
      step(-2, 1'b1, 1'b1);
    end
    chk("pattern_y", int'(y_o), PAT_EXP);

    // Extremes of the input range.
    repeat (8) step(255, 1'b1, 1'b1);
    chk("max_y", int'(y_o), 255);
    repeat (8) step(-256, 1'b1, 1'b1);
    chk("min_y", int'(y_o), -256);

    // Gapped input: invalid cycles carry junk that must be ignored.
    repeat (8) begin
      step(32, 1'b1, 1'b1);
      step(255, 1'b0, 1'b1);
    end
    chk("gap_y", int'(y_o), 32);

    // Backpressure: second result is lost, first one held.
    repeat (8) step(10, 1'b1, 1'b0);
    repeat (8) step(20, 1'b1, 1'b0);
    chk("bp_y", int'(y_o), 10);
    chk("bp_valid", int'(y_valid_o), 1);
    chk("bp_ovf", int'(ovf_o), 1);
    step(0, 1'b0, 1'b1);
    chk("bp_drain_valid", int'(y_valid_o), 0);

    // Reset mid-frame discards the partial sum.
    repeat (5) step(100, 1'b1, 1'b1);
    do_reset();
    repeat (8) step(40, 1'b1, 1'b1);
    chk("rst_frame_y", int'(y_o), 40);
    chk("rst_frame_ovf", int'(ovf_o), 0);

    // Random traffic with random gaps and random backpressure.
    repeat (800) begin
      step(int'($urandom_range(0, 511)) - 256,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) != 0);
    end
    repeat (4) step(0, 1'b0, 1'b1);
    chk("sb_empty", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
